// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK flip-flops (load/toggle/count-up/count-down).
// Optional JKSEQ_PARITY_EN adds a combinational q_parity output (= ^q).
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
`ifdef JKSEQ_PARITY_EN
    ,
    output logic             q_parity
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_TOGGLE = 2'b01,
        OP_UP     = 2'b10,
        OP_DOWN   = 2'b11
    } op_t;

    state_t           state;
    op_t              op_r;
    op_t              op_n;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] remaining;
    logic             carry;

    // Anything that is not a clean 01/10/11 (including X/Z) falls back to LOAD.
    always_comb begin
        case (cmd_op)
            2'b01:   op_n = OP_TOGGLE;
            2'b10:   op_n = OP_UP;
            2'b11:   op_n = OP_DOWN;
            default: op_n = OP_LOAD;
        endcase
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        carry = 1'b1;
        if (state == S_EXEC) begin
            case (op_r)
                OP_LOAD: begin
                    j_vec = data_r;
                    k_vec = ~data_r;
                end
                OP_TOGGLE: begin
                    j_vec = data_r;
                    k_vec = data_r;
                end
                OP_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_vec[i] = carry;
                        k_vec[i] = carry;
                        carry    = carry & q[i];
                    end
                end
                default: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        j_vec[i] = carry;
                        k_vec[i] = carry;
                        carry    = carry & ~q[i];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_r      <= OP_LOAD;
            data_r    <= '0;
            remaining <= '0;
            q         <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // JK bank: 00 hold, 01 clear, 10 set, 11 toggle
            q <= (j_vec & ~q) | (~k_vec & q);
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r      <= op_n;
                        data_r    <= cmd_data;
                        cmd_ready <= 1'b0;
                        if (op_n == OP_LOAD) begin
                            remaining <= CNT_W'(1);
                            state     <= S_EXEC;
                            busy      <= 1'b1;
                        end else if (cmd_steps == '0) begin
                            remaining <= '0;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            remaining <= cmd_steps;
                            state     <= S_EXEC;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef JKSEQ_PARITY_EN
    assign q_parity = ^q;
`endif

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Scoreboard bench for jk_bank_sequencer (WIDTH=4): driver queues expected q per busy/done cycle,
// a negedge monitor pops and compares whenever the DUT shows busy or done.
module tb_jk_bank_sequencer;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk_tb = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_steps;
    logic [3:0] j_vec;
    logic [3:0] k_vec;
    logic [3:0] q;
    logic       busy;
    logic       done;
`ifdef JKSEQ_PARITY_EN
    logic       q_parity;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];
    logic [3:0] cur;

    always #5 clk_tb = ~clk_tb;

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk_tb),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .j_vec     (j_vec),
        .k_vec     (k_vec),
        .q         (q),
        .busy      (busy),
        .done      (done)
`ifdef JKSEQ_PARITY_EN
        ,
        .q_parity  (q_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] qv, input logic b, input logic d);
        exp_t e;
        e.q = qv; e.busy = b; e.done = d;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per cycle in which busy or done is visible.
    always @(negedge clk_tb) begin
        if (mon_en) begin
`ifdef JKSEQ_PARITY_EN
            check("q_parity", {31'd0, q_parity}, {31'd0, ^q});
`endif
            if (busy || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {26'd0, busy, done, q}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("q_seq", {28'd0, q}, {28'd0, e.q});
                    check("busy_done", {30'd0, busy, done}, {30'd0, e.busy, e.done});
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] steps);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk_tb); #1;
            w++;
        end
        check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
        @(posedge clk_tb); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 50) begin
            @(posedge clk_tb); #1;
            w++;
        end
        cmd_valid = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        @(posedge clk_tb); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [3:0] val);
        push(cur, 1'b1, 1'b0);
        push(val, 1'b0, 1'b1);
        send_cmd(2'b00, val, 8'd0);
        wait_done();
        cur = val;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0; cmd_steps = 8'd0;
        cur = 4'b0000;
        repeat (2) @(posedge clk_tb);
        #1;
        check("rst_q", {28'd0, q}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_jk", {24'd0, j_vec, k_vec}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: LOAD 1010
        do_load(4'b1010);
        check("load_q", {28'd0, q}, 32'b1010);

        // 2: COUNT_UP 3 from 1110, wraps through 0000
        do_load(4'b1110);
        push(4'b1110, 1, 0); push(4'b1111, 1, 0); push(4'b0000, 1, 0); push(4'b0001, 0, 1);
        send_cmd(2'b10, 4'h0, 8'd3);
        wait_done();
        check("up_q", {28'd0, q}, 32'b0001);

        // 3a: COUNT_DOWN 2 from 0001, wraps to 1111
        push(4'b0001, 1, 0); push(4'b0000, 1, 0); push(4'b1111, 0, 1);
        send_cmd(2'b11, 4'h0, 8'd2);
        wait_done();
        check("down_q", {28'd0, q}, 32'b1111);

        // 3b: TOGGLE mask 0101 twice from 1010
        cur = 4'b1111;
        do_load(4'b1010);
        push(4'b1010, 1, 0); push(4'b1111, 1, 0); push(4'b1010, 0, 1);
        send_cmd(2'b01, 4'b0101, 8'd2);
        wait_done();
        check("toggle_q", {28'd0, q}, 32'b1010);

        // 4: TOGGLE steps=0 goes straight to done, q untouched
        do_load(4'b0110);
        push(4'b0110, 0, 1);
        send_cmd(2'b01, 4'b1111, 8'd0);
        check("zero_step_done", {30'd0, busy, done}, 32'b01);
        wait_done();
        check("zero_step_q", {28'd0, q}, 32'b0110);

        // 5: reset two edges into COUNT_UP 5 from 0011
        do_load(4'b0011);
        push(4'b0011, 1, 0); push(4'b0100, 1, 0); push(4'b0101, 1, 0);
        send_cmd(2'b10, 4'h0, 8'd5);
        repeat (2) begin @(posedge clk_tb); #1; end
        check("pre_reset_q", {28'd0, q}, 32'b0101);
        reset = 1'b1;
        @(posedge clk_tb); #1;
        check("abort_q", {28'd0, q}, 32'd0);
        check("abort_busy_done", {30'd0, busy, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk_tb); #1;
        check("abort_no_done", {30'd0, busy, done}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_queue_drained", exp_q.size(), 32'd0);

        // 6: cmd_valid held with a LOAD 1111 during COUNT_UP 3 from 0000 is ignored
        push(4'b0000, 1, 0); push(4'b0001, 1, 0); push(4'b0010, 1, 0); push(4'b0011, 0, 1);
        send_cmd(2'b10, 4'h0, 8'd3);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1111;
        wait_done();
        check("ignored_cmd_q", {28'd0, q}, 32'b0011);
        cur = 4'b0011;

        // Unknown op falls back to LOAD
        push(cur, 1, 0); push(4'b1001, 0, 1);
        send_cmd(2'bxx, 4'b1001, 8'd7);
        wait_done();
        check("xop_load_q", {28'd0, q}, 32'b1001);

        @(posedge clk_tb); #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
